// File: rtl/aes256_ctr_mode.sv
// rtl/aes256_ctr_mode.sv - AES-256 CTR-mode stream en/decryptor with AXI4-Lite key/IV programming
// Iterative core: one AES round per clock, round keys expanded alongside the state.
module aes256_ctr_mode (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [11:0]  s_axi_awaddr,
  input  logic         s_axi_awvalid,
  output logic         s_axi_awready,
  input  logic [31:0]  s_axi_wdata,
  input  logic         s_axi_wvalid,
  output logic         s_axi_wready,
  output logic [1:0]   s_axi_bresp,
  output logic         s_axi_bvalid,
  input  logic         s_axi_bready,
  input  logic [11:0]  s_axi_araddr,
  input  logic         s_axi_arvalid,
  output logic         s_axi_arready,
  output logic [31:0]  s_axi_rdata,
  output logic [1:0]   s_axi_rresp,
  output logic         s_axi_rvalid,
  input  logic         s_axi_rready,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [127:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bits 8*(255-x)+7 downto 8*(255-x); 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] top;
    top = {~x, 3'b111};
    return SBOX[top -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic final_rnd);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (final_rnd)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  // Round key j from the two preceding ones; even j takes RotWord+Rcon, odd j SubWord only.
  function automatic logic [127:0] next_rk(input logic [127:0] ka, input logic [127:0] kb,
                                           input logic [3:0] j);
    logic [31:0] t, w0, w1, w2, w3;
    logic [7:0]  rcon;
    rcon = 8'h01 << (j[3:1] - 3'd1);
    t    = kb[31:0];
    if (!j[0]) t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
    else       t = sub_word(t);
    w0 = ka[127:96] ^ t;
    w1 = ka[95:64]  ^ w0;
    w2 = ka[63:32]  ^ w1;
    w3 = ka[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic         r_awready, r_aw_full, r_wready, r_w_full, r_bvalid;
  logic [9:0]   r_awidx;
  logic [31:0]  r_wdata;
  logic         r_arready, r_rvalid;
  logic [31:0]  r_rdata;
  logic         r_ctrl, r_key_loaded;
  logic [255:0] r_key_prog, r_key;
  logic [127:0] r_iv_prog, r_ctr;
  logic         r_busy, r_last;
  logic [3:0]   r_round;
  logic [127:0] r_state, r_ka, r_kb, r_data;
  logic [127:0] r_m_tdata;
  logic         r_m_tvalid, r_m_tlast;

  logic         w_do_write, w_accept, w_s_tready;
  logic [9:0]   w_ridx;
  logic [2:0]   w_kidx;
  logic [1:0]   w_vidx, w_rvidx;
  logic [31:0]  w_rd;
  logic [127:0] w_round_out, w_next_rk;
  logic         w_unused_addr;

  assign w_unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign w_do_write    = r_aw_full & r_w_full & ~r_bvalid;
  assign w_kidx        = 3'(r_awidx - 10'd2);
  assign w_vidx        = 2'(r_awidx - 10'd10);
  assign w_ridx        = s_axi_araddr[11:2];
  assign w_rvidx       = 2'(w_ridx - 10'd10);

  always_comb begin
    w_rd = '0;
    if (w_ridx == 10'd0)
      w_rd = {31'd0, r_ctrl};
    else if (w_ridx == 10'd1)
      w_rd = {28'd0, r_key_loaded, r_m_tvalid, r_busy, r_ctrl};
    else if (w_ridx >= 10'd10 && w_ridx <= 10'd13)
      w_rd = r_iv_prog[{w_rvidx, 5'd0} +: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_awready    <= 1'b0;
      r_aw_full    <= 1'b0;
      r_awidx      <= '0;
      r_wready     <= 1'b0;
      r_w_full     <= 1'b0;
      r_wdata      <= '0;
      r_bvalid     <= 1'b0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_ctrl       <= 1'b0;
      r_key_loaded <= 1'b0;
      r_key_prog   <= '0;
      r_key        <= '0;
      r_iv_prog    <= '0;
      r_ctr        <= '0;
    end else begin
      if (s_axi_awvalid && r_awready) begin
        r_awready <= 1'b0;
        r_aw_full <= 1'b1;
        r_awidx   <= s_axi_awaddr[11:2];
      end else begin
        r_awready <= ~r_aw_full & ~r_bvalid;
      end
      if (s_axi_wvalid && r_wready) begin
        r_wready <= 1'b0;
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
      end else begin
        r_wready <= ~r_w_full & ~r_bvalid;
      end
      if (w_do_write) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (r_awidx == 10'd0) begin
          r_ctrl <= r_wdata[0];
          // Falling edge of load_key_and_iv commits the programmed key and IV.
          if (r_ctrl && !r_wdata[0]) begin
            r_key        <= r_key_prog;
            r_ctr        <= r_iv_prog;
            r_key_loaded <= 1'b1;
          end
        end else if (r_awidx >= 10'd2 && r_awidx <= 10'd9) begin
          r_key_prog[{w_kidx, 5'd0} +: 32] <= r_wdata;
        end else if (r_awidx >= 10'd10 && r_awidx <= 10'd13) begin
          r_iv_prog[{w_vidx, 5'd0} +: 32] <= r_wdata;
        end
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_accept) r_ctr <= r_ctr + 128'd1;
      if (s_axi_arvalid && r_arready) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rd;
      end else begin
        if (r_rvalid && s_axi_rready) r_rvalid <= 1'b0;
        r_arready <= ~r_rvalid;
      end
    end
  end

  assign w_s_tready  = ~r_ctrl & r_key_loaded & ~r_busy & ~r_m_tvalid;
  assign w_accept    = s_axis_tvalid & w_s_tready;
  assign w_round_out = aes_round(r_state, r_kb, r_round == 4'd14);
  assign w_next_rk   = next_rk(r_ka, r_kb, r_round + 4'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_round    <= '0;
      r_state    <= '0;
      r_ka       <= '0;
      r_kb       <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else begin
      if (r_m_tvalid && m_axis_tready) r_m_tvalid <= 1'b0;
      if (w_accept) begin
        r_state <= r_ctr ^ r_key[255:128];
        r_ka    <= r_key[255:128];
        r_kb    <= r_key[127:0];
        r_data  <= s_axis_tdata;
        r_last  <= s_axis_tlast;
        r_round <= 4'd1;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        if (r_round == 4'd14) begin
          r_busy     <= 1'b0;
          r_m_tdata  <= r_data ^ w_round_out;
          r_m_tvalid <= 1'b1;
          r_m_tlast  <= r_last;
        end else begin
          r_state <= w_round_out;
          r_ka    <= r_kb;
          r_kb    <= w_next_rk;
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign s_axis_tready = w_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;

endmodule

// File: tb/tb_aes256_ctr_mode.sv
// tb/tb_aes256_ctr_mode.sv - self-checking bench for aes256_ctr_mode against a byte-level AES/CTR model
module tb_aes256_ctr_mode;

  logic         clk, rst_n;
  logic [11:0]  s_axi_awaddr, s_axi_araddr;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]  s_axi_wdata, s_axi_rdata;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] s_axis_tdata, m_axis_tdata;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sb_m [256];
  logic [255:0] m_key;
  logic [127:0] m_ctr;

  aes256_ctr_mode dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish by 2ms");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  // Straight FIPS-197 byte-array encryption with a full 60-word key schedule.
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] blk);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_m[st[(i + 4*(i%4)) % 16]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 14) begin
          st[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          st[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  function automatic logic [127:0] model_block(input logic [127:0] pt);
    logic [127:0] ks;
    ks    = aes_ref(m_key, m_ctr);
    m_ctr = m_ctr + 128'd1;
    return pt ^ ks;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
    int t;
    bit aw_done, w_done;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata  = data; s_axi_wvalid  = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
      @(negedge clk); t++;
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done) s_axi_wvalid = 1'b0;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1; t = 0;
    while (!s_axi_bvalid && t < 50) begin @(negedge clk); t++; end
    check($sformatf("axi_write_%0h", addr), 128'({aw_done, w_done, s_axi_bvalid, s_axi_bresp}),
          128'h1c);
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
    int t;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; t = 0;
    while (!s_axi_arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1; t = 0;
    while (!s_axi_rvalid && t < 50) begin @(negedge clk); t++; end
    data = (s_axi_rvalid && s_axi_rresp == 2'b00) ? s_axi_rdata : 32'hxxxxxxxx;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic load(input logic [255:0] key, input logic [127:0] iv);
    axi_write(12'h000, 32'h1);
    for (int n = 0; n < 8; n++) axi_write(12'(8 + 4*n), key[32*n +: 32]);
    for (int n = 0; n < 4; n++) axi_write(12'(40 + 4*n), iv[32*n +: 32]);
    axi_write(12'h000, 32'h0);
    m_key = key;
    m_ctr = iv;
  endtask

  task automatic stream_block(input logic [127:0] pt, input logic last, input int hold,
                              output logic [127:0] ct, output logic lst);
    int t, k;
    logic [127:0] snap;
    logic [31:0]  st;
    bit stable;
    @(negedge clk);
    s_axis_tdata = pt; s_axis_tlast = last; s_axis_tvalid = 1'b1; t = 0;
    while (!s_axis_tready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    s_axis_tvalid = 1'b0; k = 0;
    while (!m_axis_tvalid && k < 100) begin @(negedge clk); k++; end
    check("latency", 128'(k), 128'd14);
    if (hold > 0) begin
      snap = m_axis_tdata; stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (m_axis_tdata !== snap || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) stable = 1'b0;
      end
      check("bp_stable", 128'(stable), 128'd1);
      axi_read(12'h004, st);
      check("bp_status_pending", 128'(st[2]), 128'd1);
    end
    ct = m_axis_tdata; lst = m_axis_tlast;
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
  endtask

  localparam logic [255:0] NIST_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] NIST_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  logic [127:0] nist_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] nist_ct [4] = '{128'h601ec313775789a5b7a7f504bbf3d228, 128'hf443e3ca4d62b59aca84e990cacaf5c5,
                                128'h2b0930daa23de94ce87017ba2d84988d, 128'hdfc9c58db67aada613c2dd08457941a6};

  initial begin
    logic [127:0] ct, pt, pt2, ct2;
    logic [255:0] key;
    logic [31:0]  rd;
    logic         lst, last;
    int           t;
    bit           seen_v, seen_r;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; b = inv;
      for (int r = 0; r < 4; r++) begin b = {b[6:0], b[7]}; s = s ^ b; end
      sb_m[x] = s ^ 8'h63;
    end

    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    m_key = '0; m_ctr = '0;
    repeat (4) @(negedge clk);
    check("rst_handshakes", 128'({s_axis_tready, m_axis_tvalid, s_axi_awready, s_axi_wready,
                                  s_axi_arready, s_axi_bvalid, s_axi_rvalid}), 128'd0);
    check("rst_m_tdata", m_axis_tdata, 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_key_tready", 128'(s_axis_tready), 128'd0);
    axi_read(12'h004, rd);
    check("rst_status", 128'(rd), 128'd0);

    load(NIST_KEY, NIST_IV);
    for (int i = 0; i < 4; i++) begin
      stream_block(nist_pt[i], i == 3, 0, ct, lst);
      check($sformatf("nist_ct%0d", i), ct, nist_ct[i]);
      check($sformatf("nist_last%0d", i), 128'(lst), 128'(i == 3));
      check($sformatf("nist_model%0d", i), ct, model_block(nist_pt[i]));
    end

    axi_write(12'h000, 32'h1);
    repeat (5) @(negedge clk);
    check("ctrl1_tready", 128'(s_axis_tready), 128'd0);
    axi_read(12'h004, rd);
    check("ctrl1_status", 128'(rd), 128'h9);
    axi_write(12'h000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      stream_block(nist_pt[i], i == 3, 0, ct, lst);
      check($sformatf("reload_ct%0d", i), ct, nist_ct[i]);
    end

    axi_read(12'h034, rd);
    check("iv3_readback", 128'(rd), 128'hf0f1f2f3);
    axi_read(12'h028, rd);
    check("iv0_readback", 128'(rd), 128'hfcfdfeff);
    axi_read(12'h008, rd);
    check("key_read_zero", 128'(rd), 128'd0);
    axi_read(12'h040, rd);
    check("unmapped_zero", 128'(rd), 128'd0);

    load(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
         128'h00112233445566778899aabbccddeeff);
    stream_block(128'd0, 1'b1, 0, ct, lst);
    check("fips_c3", ct, 128'h8ea2b7ca516745bfeafc49904b496089);

    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load(key, {$urandom, $urandom, $urandom, $urandom});
    pt = {$urandom, $urandom, $urandom, $urandom};
    stream_block(pt, 1'b0, 50, ct, lst);
    check("bp_ct", ct, model_block(pt));
    pt = {$urandom, $urandom, $urandom, $urandom};
    stream_block(pt, 1'b1, 0, ct, lst);
    check("bp_next_ct", ct, model_block(pt));

    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load(key, {128{1'b1}});
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    stream_block(pt, 1'b0, 0, ct, lst);
    check("wrap_ct0", ct, model_block(pt));
    stream_block(pt2, 1'b1, 0, ct2, lst);
    check("wrap_ct1", ct2, model_block(pt2));
    check("wrap_ks_zero", ct2 ^ pt2, aes_ref(key, 128'd0));

    for (int l = 0; l < 2; l++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load(key, {$urandom, $urandom, $urandom, $urandom});
      for (int b = 0; b < 4; b++) begin
        pt   = {$urandom, $urandom, $urandom, $urandom};
        last = 1'($urandom_range(0, 1));
        stream_block(pt, last, 0, ct, lst);
        check($sformatf("rand_ct_%0d_%0d", l, b), ct, model_block(pt));
        check($sformatf("rand_last_%0d_%0d", l, b), 128'(lst), 128'(last));
      end
    end

    @(negedge clk);
    s_axis_tdata = {$urandom, $urandom, $urandom, $urandom}; s_axis_tvalid = 1'b1; t = 0;
    while (!s_axis_tready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_v = 1'b0; seen_r = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) seen_v = 1'b1;
      if (s_axis_tready) seen_r = 1'b1;
    end
    check("midrst_no_output", 128'(seen_v), 128'd0);
    check("midrst_no_tready", 128'(seen_r), 128'd0);
    check("midrst_m_tdata", m_axis_tdata, 128'd0);
    axi_read(12'h000, rd);
    check("midrst_ctrl", 128'(rd), 128'd0);
    axi_read(12'h004, rd);
    check("midrst_status", 128'(rd), 128'd0);
    for (int n = 0; n < 4; n++) begin
      axi_read(12'(40 + 4*n), rd);
      check($sformatf("midrst_iv%0d", n), 128'(rd), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
